// File: rtl/trees_burst_scheduler.sv
// Splits a host tree-inference job into MAX_BURST-sample launches of the accelerator and
// rebases its DMA indices per chunk. Optional busy-cycle counter: TREES_SCHED_PERF_EN.
module trees_burst_scheduler #(
    parameter int unsigned N_FEATURE = 32,
    parameter int unsigned MAX_BURST = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] conf_info_load_trees,
    input  logic [31:0] conf_info_total_len,
    input  logic [31:0] conf_info_feat_base,
    input  logic [31:0] conf_info_pred_base,
    input  logic        conf_done,
    output logic        acc_done,
    output logic [31:0] acc_conf_load_trees,
    output logic [31:0] acc_conf_burst_len,
    output logic        acc_conf_done,
    input  logic        acc_done_in,
    input  logic [31:0] acc_rd_index,
    input  logic [31:0] acc_wr_index,
    output logic [31:0] dma_rd_index,
    output logic [31:0] dma_wr_index,
    output logic [15:0] chunk_idx,
    output logic        busy,
    output logic [31:0] perf_cycles
);

    localparam logic [31:0] MaxBurst = 32'(MAX_BURST);
    localparam logic [31:0] RdStep   = 32'((MAX_BURST * N_FEATURE) >> 1);
    localparam logic [31:0] WrStep   = 32'(MAX_BURST >> 3);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] load_trees_q, load_trees_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] rd_off_q, rd_off_d;
    logic [31:0] wr_off_q, wr_off_d;
    logic [15:0] chunk_idx_q, chunk_idx_d;
    logic [31:0] burst_len_q, burst_len_d;
    logic [31:0] conf_load_q, conf_load_d;
    logic        conf_done_q, conf_done_d;
    logic        acc_done_q, acc_done_d;
    logic [31:0] remaining_next;

    // burst_len_q still holds the length of the chunk that just finished
    assign remaining_next = remaining_q - burst_len_q;

    always_comb begin
        state_d      = state_q;
        load_trees_d = load_trees_q;
        remaining_d  = remaining_q;
        rd_off_d     = rd_off_q;
        wr_off_d     = wr_off_q;
        chunk_idx_d  = chunk_idx_q;
        burst_len_d  = burst_len_q;
        conf_load_d  = conf_load_q;
        conf_done_d  = 1'b0;
        acc_done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (conf_done) begin
                    load_trees_d = conf_info_load_trees;
                    remaining_d  = conf_info_total_len;
                    rd_off_d     = conf_info_feat_base;
                    wr_off_d     = conf_info_pred_base;
                    chunk_idx_d  = 16'd0;
                    if (!conf_info_load_trees[0] && (conf_info_total_len == 32'd0)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StLaunch;
                    end
                end
            end
            StLaunch: begin
                if (load_trees_q[0]) begin
                    burst_len_d = 32'd0;
                end else begin
                    burst_len_d = (remaining_q < MaxBurst) ? remaining_q : MaxBurst;
                end
                conf_load_d = load_trees_q;
                conf_done_d = 1'b1;
                state_d     = StWait;
            end
            StWait: begin
                if (acc_done_in) begin
                    remaining_d = remaining_next;
                    rd_off_d    = rd_off_q + RdStep;
                    wr_off_d    = wr_off_q + WrStep;
                    chunk_idx_d = chunk_idx_q + 16'd1;
                    if (load_trees_q[0] || (remaining_next == 32'd0)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StLaunch;
                    end
                end
            end
            StDone: begin
                acc_done_d = 1'b1;
                state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            load_trees_q <= '0;
            remaining_q  <= '0;
            rd_off_q     <= '0;
            wr_off_q     <= '0;
            chunk_idx_q  <= '0;
            burst_len_q  <= '0;
            conf_load_q  <= '0;
            conf_done_q  <= 1'b0;
            acc_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_trees_q <= load_trees_d;
            remaining_q  <= remaining_d;
            rd_off_q     <= rd_off_d;
            wr_off_q     <= wr_off_d;
            chunk_idx_q  <= chunk_idx_d;
            burst_len_q  <= burst_len_d;
            conf_load_q  <= conf_load_d;
            conf_done_q  <= conf_done_d;
            acc_done_q   <= acc_done_d;
        end
    end

    assign busy                = (state_q != StIdle);
    assign acc_done            = acc_done_q;
    assign acc_conf_done       = conf_done_q;
    assign acc_conf_load_trees = conf_load_q;
    assign acc_conf_burst_len  = burst_len_q;
    assign chunk_idx           = chunk_idx_q;
    assign dma_rd_index        = acc_rd_index + rd_off_q;
    assign dma_wr_index        = acc_wr_index + wr_off_q;

`ifdef TREES_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if ((state_q == StIdle) && conf_done) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_trees_burst_scheduler.sv
// Randomized self-checking bench for trees_burst_scheduler; expected launch schedule, offsets
// and completion timing come from a job-level model built before each job is driven.
module tb_trees_burst_scheduler;

    localparam int unsigned N_FEATURE = 32;
    localparam int unsigned MAX_BURST = 5000;
    localparam logic [31:0] RD_STEP = 32'(MAX_BURST * N_FEATURE / 2);
    localparam logic [31:0] WR_STEP = 32'(MAX_BURST / 8);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] conf_info_load_trees = '0;
    logic [31:0] conf_info_total_len = '0;
    logic [31:0] conf_info_feat_base = '0;
    logic [31:0] conf_info_pred_base = '0;
    logic        conf_done = 1'b0;
    logic        acc_done;
    logic [31:0] acc_conf_load_trees;
    logic [31:0] acc_conf_burst_len;
    logic        acc_conf_done;
    logic        acc_done_in = 1'b0;
    logic [31:0] acc_rd_index = '0;
    logic [31:0] acc_wr_index = '0;
    logic [31:0] dma_rd_index;
    logic [31:0] dma_wr_index;
    logic [15:0] chunk_idx;
    logic        busy;
    logic [31:0] perf_cycles;

    int checks = 0;
    int errors = 0;

    trees_burst_scheduler #(
        .N_FEATURE(N_FEATURE),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .conf_info_load_trees(conf_info_load_trees),
        .conf_info_total_len (conf_info_total_len),
        .conf_info_feat_base (conf_info_feat_base),
        .conf_info_pred_base (conf_info_pred_base),
        .conf_done           (conf_done),
        .acc_done            (acc_done),
        .acc_conf_load_trees (acc_conf_load_trees),
        .acc_conf_burst_len  (acc_conf_burst_len),
        .acc_conf_done       (acc_conf_done),
        .acc_done_in         (acc_done_in),
        .acc_rd_index        (acc_rd_index),
        .acc_wr_index        (acc_wr_index),
        .dma_rd_index        (dma_rd_index),
        .dma_wr_index        (dma_wr_index),
        .chunk_idx           (chunk_idx),
        .busy                (busy),
        .perf_cycles         (perf_cycles)
    );

    always #5 clk = ~clk;

    // Cycle 0 carries conf_done; the loop then samples every cycle at the falling edge.
    task automatic run_job(input logic [31:0] lt, input logic [31:0] tot, input logic [31:0] fb,
                           input logic [31:0] pb, input bit stray);
        int unsigned lens[$];
        int unsigned launch_at[$];
        int unsigned done_at[$];
        int unsigned rem;
        int unsigned t;
        int unsigned a;
        logic [31:0] rdv;
        logic [31:0] wrv;
        logic [31:0] exp_perf;
        bit          exp_launch;
        if (lt[0]) begin
            lens.push_back(0);
        end else begin
            rem = tot;
            while (rem != 0) begin
                t = (rem < MAX_BURST) ? rem : MAX_BURST;
                lens.push_back(t);
                rem -= t;
            end
        end
        t = 2;
        foreach (lens[i]) begin
            launch_at.push_back(t);
            done_at.push_back(t + $urandom_range(0, 4));
            t = done_at[i] + 2;
        end
        a = t;
`ifdef TREES_SCHED_PERF_EN
        exp_perf = 32'(a - 1);
`else
        exp_perf = 32'd0;
`endif
        @(negedge clk);
        conf_info_load_trees = lt;
        conf_info_total_len  = tot;
        conf_info_feat_base  = fb;
        conf_info_pred_base  = pb;
        conf_done            = 1'b1;
        for (int c = 1; c <= int'(a) + 1; c++) begin
            @(negedge clk);
            conf_done   = 1'b0;
            acc_done_in = 1'b0;
            exp_launch  = 1'b0;
            foreach (launch_at[k]) if (launch_at[k] == c) exp_launch = 1'b1;
            checks++;
            if (acc_conf_done !== exp_launch) begin
                errors++;
                $display("FAIL conf_done_pulse cycle %0d: got %b expected %b", c, acc_conf_done,
                         exp_launch);
            end
            checks++;
            if (acc_done !== (c == int'(a))) begin
                errors++;
                $display("FAIL acc_done_timing cycle %0d: got %b expected %b", c, acc_done,
                         (c == int'(a)));
            end
            checks++;
            if (busy !== (c < int'(a))) begin
                errors++;
                $display("FAIL busy cycle %0d: got %b expected %b", c, busy, (c < int'(a)));
            end
            if (c == int'(a)) begin
                checks++;
                if (perf_cycles !== exp_perf) begin
                    errors++;
                    $display("FAIL perf_cycles: got %0d expected %0d", perf_cycles, exp_perf);
                end
            end
            foreach (launch_at[k]) begin
                if (launch_at[k] == c) begin
                    checks++;
                    if (acc_conf_burst_len !== 32'(lens[k])) begin
                        errors++;
                        $display("FAIL burst_len chunk %0d: got %0d expected %0d", k,
                                 acc_conf_burst_len, lens[k]);
                    end
                    checks++;
                    if (acc_conf_load_trees !== lt) begin
                        errors++;
                        $display("FAIL load_trees chunk %0d: got %h expected %h", k,
                                 acc_conf_load_trees, lt);
                    end
                    checks++;
                    if (chunk_idx !== 16'(k)) begin
                        errors++;
                        $display("FAIL chunk_idx: got %0d expected %0d", chunk_idx, k);
                    end
                    rdv = $urandom_range(0, 1000);
                    wrv = $urandom;
                    acc_rd_index = rdv;
                    acc_wr_index = wrv;
                    #1;
                    checks++;
                    if (dma_rd_index !== rdv + fb + 32'(k) * RD_STEP) begin
                        errors++;
                        $display("FAIL dma_rd_index chunk %0d: got %h expected %h", k,
                                 dma_rd_index, rdv + fb + 32'(k) * RD_STEP);
                    end
                    checks++;
                    if (dma_wr_index !== wrv + pb + 32'(k) * WR_STEP) begin
                        errors++;
                        $display("FAIL dma_wr_index chunk %0d: got %h expected %h", k,
                                 dma_wr_index, wrv + pb + 32'(k) * WR_STEP);
                    end
                end
                if (done_at[k] == c) acc_done_in = 1'b1;
                if (stray && (launch_at[k] == c + 1)) acc_done_in = 1'b1;
            end
            // Junk requests while busy; the DONE cycle also gets a stray acc_done_in.
            if (stray && (c < int'(a))) begin
                if (c == int'(a) - 1) acc_done_in = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    conf_done            = 1'b1;
                    conf_info_load_trees = $urandom;
                    conf_info_total_len  = $urandom;
                    conf_info_feat_base  = $urandom;
                    conf_info_pred_base  = $urandom;
                end
            end
        end
        conf_done   = 1'b0;
        acc_done_in = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({acc_done, acc_conf_done, busy} !== 3'b000) begin
            errors++;
            $display("FAIL %s_ctrl: got done=%b conf=%b busy=%b expected 000", tag, acc_done,
                     acc_conf_done, busy);
        end
        checks++;
        if ({acc_conf_load_trees, acc_conf_burst_len, chunk_idx, perf_cycles} !== '0) begin
            errors++;
            $display("FAIL %s_regs: got lt=%h len=%0d chunk=%0d perf=%0d expected all 0", tag,
                     acc_conf_load_trees, acc_conf_burst_len, chunk_idx, perf_cycles);
        end
        checks++;
        if ({dma_rd_index, dma_wr_index} !== {acc_rd_index, acc_wr_index}) begin
            errors++;
            $display("FAIL %s_offsets: got rd=%h wr=%h expected rd=%h wr=%h", tag, dma_rd_index,
                     dma_wr_index, acc_rd_index, acc_wr_index);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        acc_rd_index = 32'h1234;
        acc_wr_index = 32'h5678;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
    endtask

    task automatic test_single();
        run_job(32'd0, 32'd100, 32'h1000, 32'h8000, 1'b0);
    endtask

    task automatic test_multi_chunk();
        run_job(32'd0, 32'd12000, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_tree_load();
        run_job(32'd1, 32'd12000, 32'h40, 32'h80, 1'b0);
    endtask

    task automatic test_zero_len();
        run_job(32'd0, 32'd0, 32'h10, 32'h20, 1'b0);
    endtask

    task automatic test_stray_inputs();
        run_job(32'd0, 32'd12000, 32'd0, 32'd0, 1'b1);
        run_job(32'd0, 32'd0, 32'd5, 32'd6, 1'b1);
    endtask

    task automatic test_reset_mid_job();
        @(negedge clk);
        conf_info_load_trees = 32'd0;
        conf_info_total_len  = 32'd12000;
        conf_info_feat_base  = 32'd0;
        conf_info_pred_base  = 32'd0;
        conf_done            = 1'b1;
        @(negedge clk);
        conf_done = 1'b0;
        @(negedge clk);
        acc_done_in = 1'b1;
        @(negedge clk);
        acc_done_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({acc_conf_done, chunk_idx} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL abort_setup: got conf=%b chunk=%0d expected conf=1 chunk=1",
                     acc_conf_done, chunk_idx);
        end
        acc_rd_index = 32'h77;
        acc_wr_index = 32'h99;
        rst = 1'b0;
        #1;
        check_reset_values("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (acc_done !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: got %b expected 0", acc_done);
            end
        end
        rst = 1'b1;
        run_job(32'd0, 32'd100, 32'h1000, 32'h8000, 1'b0);
    endtask

    task automatic test_random_jobs();
        logic [31:0] lt;
        for (int j = 0; j < 6; j++) begin
            lt = ($urandom_range(0, 4) == 0) ? 32'(($urandom & 32'hFFFF_FFFE) | 32'd1)
                                             : ($urandom & 32'hFFFF_FFFE);
            run_job(lt, 32'($urandom_range(0, 16000)), $urandom, $urandom,
                    bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_chunk();
        test_tree_load();
        test_zero_len();
        test_stray_inputs();
        test_reset_mid_job();
        test_random_jobs();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
